// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_pkg
// Brief    : ALU select, MIPS opcode/funct and FSM state constants for alu_issue
// Revision : 1.0
// ============================================================================
package alu_issue_pkg;

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_issue_dec.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_dec
// Brief    : MIPS opcode/funct to ALU select decode; ALU_ISSUE_BNE_EN enables BNE
// Revision : 1.0
// ============================================================================
module alu_issue_dec
    import alu_issue_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [3:0] sel_o,
    output logic       is_beq_o,
    output logic       is_bne_o,
    output logic       illegal_o
);

    always_comb begin
        sel_o     = SEL_AND;
        is_beq_o  = 1'b0;
        is_bne_o  = 1'b0;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_AND:  sel_o = SEL_AND;
                    FN_OR:   sel_o = SEL_OR;
                    FN_ADD:  sel_o = SEL_ADD;
                    FN_SUB:  sel_o = SEL_SUB;
                    FN_SLT:  sel_o = SEL_SLT;
                    FN_NOR:  sel_o = SEL_NOR;
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_ADDI: sel_o = SEL_ADD;
            OP_ANDI: sel_o = SEL_AND;
            OP_ORI:  sel_o = SEL_OR;
            OP_SLTI: sel_o = SEL_SLT;
            OP_LW:   sel_o = SEL_ADD;
            OP_SW:   sel_o = SEL_ADD;
            OP_BEQ: begin
                sel_o    = SEL_SUB;
                is_beq_o = 1'b1;
            end
`ifdef ALU_ISSUE_BNE_EN
            OP_BNE: begin
                sel_o    = SEL_SUB;
                is_bne_o = 1'b1;
            end
`endif
            default: illegal_o = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Brief    : Valid/ready issue front end for the single-cycle ALU (IDLE/EXEC/RESP).
//            Build macro ALU_ISSUE_BNE_EN enables BNE decode.
// Revision : 1.0
// ============================================================================
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_opcode,
    input  logic [5:0]       req_funct,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      alu_op1,
    output logic [31:0]      alu_op2,
    output logic [3:0]       alu_sel,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_taken,
    output logic             rsp_illegal,
    output logic [TAG_W-1:0] rsp_tag
);

    state_t             state_q, state_d;
    logic [31:0]        op1_q, op2_q;
    logic [3:0]         sel_q;
    logic               beq_q, bne_q, ill_q;
    logic [TAG_W-1:0]   tag_q;
    logic [31:0]        rsp_result_q;
    logic               rsp_zero_q, rsp_taken_q, rsp_illegal_q;
    logic [TAG_W-1:0]   rsp_tag_q;

    logic [3:0]         w_dec_sel;
    logic               w_dec_beq, w_dec_bne, w_dec_ill;
    logic               w_accept;

    alu_issue_dec u_dec (
        .opcode_i  (req_opcode),
        .funct_i   (req_funct),
        .sel_o     (w_dec_sel),
        .is_beq_o  (w_dec_beq),
        .is_bne_o  (w_dec_bne),
        .illegal_o (w_dec_ill)
    );

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    assign req_ready = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_RESP) & rsp_ready));
    assign w_accept  = req_valid & req_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = req_valid ? ST_EXEC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            op1_q         <= '0;
            op2_q         <= '0;
            sel_q         <= '0;
            beq_q         <= 1'b0;
            bne_q         <= 1'b0;
            ill_q         <= 1'b0;
            tag_q         <= '0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_taken_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
            rsp_tag_q     <= '0;
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                op1_q <= req_a;
                op2_q <= req_b;
                sel_q <= w_dec_sel;
                beq_q <= w_dec_beq;
                bne_q <= w_dec_bne;
                ill_q <= w_dec_ill;
                tag_q <= req_tag;
            end
            // Branch flags are never set for illegal ops, so taken needs no extra mask.
            if (state_q == ST_EXEC) begin
                rsp_result_q  <= ill_q ? 32'd0 : alu_result;
                rsp_zero_q    <= ill_q | alu_zero;
                rsp_taken_q   <= (beq_q & alu_zero) | (bne_q & ~alu_zero);
                rsp_illegal_q <= ill_q;
                rsp_tag_q     <= tag_q;
            end
        end
    end

    assign alu_op1     = op1_q;
    assign alu_op2     = op2_q;
    assign alu_sel     = sel_q;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_result  = rsp_result_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_taken   = rsp_taken_q;
    assign rsp_illegal = rsp_illegal_q;
    assign rsp_tag     = rsp_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue
// Brief    : Self-checking bench for alu_issue with an ALU model and a
//            reference model of the issue/response behaviour.
// Revision : 1.0
// ============================================================================
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_opcode;
    logic [5:0]  req_funct;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_tag;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_sel;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_taken;
    logic        rsp_illegal;
    logic [3:0]  rsp_tag;

    int errors = 0;
    int checks = 0;

    logic [3:0]  e_sel;
    logic [31:0] e_res;
    logic        e_zero, e_taken, e_ill;
    logic [31:0] e_a, e_b;
    logic [3:0]  e_tag;

    alu_issue #(.TAG_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_funct   (req_funct),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_tag     (req_tag),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_sel     (alu_sel),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_taken   (rsp_taken),
        .rsp_illegal (rsp_illegal),
        .rsp_tag     (rsp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle ALU behaviour (unsigned SLT).
    always_comb begin
        case (alu_sel)
            4'b0000: alu_result = alu_op1 & alu_op2;
            4'b0001: alu_result = alu_op1 | alu_op2;
            4'b0010: alu_result = alu_op1 + alu_op2;
            4'b0110: alu_result = alu_op1 - alu_op2;
            4'b0111: alu_result = (alu_op1 < alu_op2) ? 32'd1 : 32'd0;
            4'b1100: alu_result = ~(alu_op1 | alu_op2);
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome of one instruction, straight from the opcode/funct table.
    task automatic model(input logic [5:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        e_ill = 1'b0; e_taken = 1'b0; e_sel = 4'd0; e_res = 32'd0;
        case (op)
            6'h00: case (f)
                6'h24:   begin e_sel = 4'd0;  e_res = a & b; end
                6'h25:   begin e_sel = 4'd1;  e_res = a | b; end
                6'h20:   begin e_sel = 4'd2;  e_res = a + b; end
                6'h22:   begin e_sel = 4'd6;  e_res = a - b; end
                6'h2a:   begin e_sel = 4'd7;  e_res = {31'd0, a < b}; end
                6'h27:   begin e_sel = 4'd12; e_res = ~(a | b); end
                default: e_ill = 1'b1;
            endcase
            6'h08, 6'h23, 6'h2b: begin e_sel = 4'd2; e_res = a + b; end
            6'h0c: begin e_sel = 4'd0; e_res = a & b; end
            6'h0d: begin e_sel = 4'd1; e_res = a | b; end
            6'h0a: begin e_sel = 4'd7; e_res = {31'd0, a < b}; end
            6'h04: begin e_sel = 4'd6; e_res = a - b; e_taken = (a == b); end
`ifdef ALU_ISSUE_BNE_EN
            6'h05: begin e_sel = 4'd6; e_res = a - b; e_taken = (a != b); end
`endif
            default: e_ill = 1'b1;
        endcase
        if (e_ill) begin
            e_sel = 4'd0; e_res = 32'd0; e_taken = 1'b0;
        end
        e_zero = e_ill | (e_res == 32'd0);
        e_a = a; e_b = b;
    endtask

    // Called at negedge+1; chain=1 retires the pending response on the same edge.
    task automatic issue(input logic [5:0] op, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag, input bit chain);
        model(op, f, a, b);
        e_tag      = tag;
        req_opcode = op; req_funct = f; req_a = a; req_b = b; req_tag = tag;
        req_valid  = 1'b1;
        rsp_ready  = chain;
        #1 chk("req_ready_pre_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = $urandom; req_b = $urandom;
        #1;
        chk("exec_alu_sel", {28'd0, alu_sel}, {28'd0, e_sel});
        chk("exec_alu_op1", alu_op1, e_a);
        chk("exec_alu_op2", alu_op2, e_b);
        chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("exec_req_ready", {31'd0, req_ready}, 32'd0);
    endtask

    task automatic check_resp(input int bp);
        for (int c = 0; c <= bp; c++) begin
            @(posedge clk); @(negedge clk); #1;
            chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rsp_result", rsp_result, e_res);
            chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e_zero});
            chk("rsp_taken", {31'd0, rsp_taken}, {31'd0, e_taken});
            chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, e_ill});
            chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, e_tag});
            chk("resp_alu_op1_stable", alu_op1, e_a);
            chk("resp_req_ready_bp", {31'd0, req_ready}, 32'd0);
        end
    endtask

    task automatic retire();
        rsp_ready = 1'b1;
        #1 chk("retire_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    logic [5:0] fn_tab [6];
    logic [5:0] op_tab [8];

    initial begin
        bit          pending;
        logic [31:0] ra, rb;
        logic [5:0]  rop, rfn;
        int          k;

        fn_tab[0] = 6'h24; fn_tab[1] = 6'h25; fn_tab[2] = 6'h20;
        fn_tab[3] = 6'h22; fn_tab[4] = 6'h2a; fn_tab[5] = 6'h27;
        op_tab[0] = 6'h08; op_tab[1] = 6'h0c; op_tab[2] = 6'h0d; op_tab[3] = 6'h0a;
        op_tab[4] = 6'h23; op_tab[5] = 6'h2b; op_tab[6] = 6'h04; op_tab[7] = 6'h05;

        rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_opcode = '0; req_funct = '0; req_a = '0; req_b = '0; req_tag = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_alu_op1", alu_op1, 32'd0);
        chk("reset_alu_op2", alu_op2, 32'd0);
        chk("reset_alu_sel", {28'd0, alu_sel}, 32'd0);
        chk("reset_rsp_result", rsp_result, 32'd0);
        chk("reset_rsp_flags", {28'd0, rsp_zero, rsp_taken, rsp_illegal, 1'b0}, 32'd0);
        chk("reset_rsp_tag", {28'd0, rsp_tag}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_reset_req_ready", {31'd0, req_ready}, 32'd1);

        // ADD 5+7
        issue(6'h00, 6'h20, 32'd5, 32'd7, 4'h3, 1'b0);
        check_resp(0);
        chk("add_result_const", rsp_result, 32'd12);
        retire();

        // SUB 9-9 then BEQ 3,3 back-to-back
        issue(6'h00, 6'h22, 32'd9, 32'd9, 4'h5, 1'b0);
        check_resp(0);
        chk("sub_zero_const", {31'd0, rsp_zero}, 32'd1);
        issue(6'h04, 6'h00, 32'd3, 32'd3, 4'h6, 1'b1);
        check_resp(0);
        chk("beq_taken_const", {31'd0, rsp_taken}, 32'd1);
        retire();

        // NOR 0,0 held under 5 cycles of backpressure
        issue(6'h00, 6'h27, 32'd0, 32'd0, 4'h7, 1'b0);
        check_resp(5);
        chk("nor_result_const", rsp_result, 32'hFFFF_FFFF);
        retire();

        // Illegal funct, BNE 1,2, unsigned SLT
        issue(6'h00, 6'h00, 32'h1234, 32'h1234, 4'h8, 1'b0);
        check_resp(1);
        retire();
        issue(6'h05, 6'h00, 32'd1, 32'd2, 4'h9, 1'b0);
        check_resp(0);
        retire();
        issue(6'h00, 6'h2a, 32'hFFFF_FFFF, 32'd1, 4'hA, 1'b0);
        check_resp(0);
        chk("slt_unsigned_const", rsp_result, 32'd0);
        retire();

        // Randomized mix with random chaining and backpressure
        pending = 1'b0;
        for (int i = 0; i < 60; i++) begin
            k  = $urandom_range(0, 15);
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            rfn = 6'($urandom);
            if (k < 6) begin rop = 6'h00; rfn = fn_tab[k]; end
            else if (k < 14) rop = op_tab[k-6];
            else rop = 6'($urandom);
            if (pending && ($urandom_range(0, 1) == 0)) begin
                retire();
                issue(rop, rfn, ra, rb, 4'($urandom), 1'b0);
            end else begin
                issue(rop, rfn, ra, rb, 4'($urandom), pending);
            end
            check_resp($urandom_range(0, 2));
            pending = 1'b1;
        end
        retire();

        // Reset during EXEC drops the operation
        issue(6'h00, 6'h20, 32'd1, 32'd1, 4'hB, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_exec_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_exec_alu_op1", alu_op1, 32'd0);
        chk("rst_exec_alu_sel", {28'd0, alu_sel}, 32'd0);
        chk("rst_exec_rsp_result", rsp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_release_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_no_response", {31'd0, rsp_valid}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue.md
# alu_issue

Sequential front end for the single-cycle ALU (`op1`/`op2`/`selOp` in, `resultado`/`zeroFlag` out). It accepts decoded-instruction requests over a valid/ready handshake and translates MIPS opcode/funct into the 4-bit ALU select. It registers the operands onto the ALU, captures the result and zero flag, and returns a response with branch-taken and illegal indications under valid/ready backpressure. It sits between the instruction decode stage and the ALU.

## Interface
- `TAG_W`, 4: width of the request tag echoed on the response.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when high with `req_valid` at a rising edge.
- `req_opcode` in 6: MIPS opcode.
- `req_funct` in 6: MIPS funct; used only when `req_opcode`=000000.
- `req_a` in 32: first operand (rs value).
- `req_b` in 32: second operand (rt value or immediate already extended by the caller).
- `req_tag` in TAG_W: opaque tag.
- `alu_op1` out 32: drives ALU `op1`.
- `alu_op2` out 32: drives ALU `op2`.
- `alu_sel` out 4: drives ALU `selOp`.
- `alu_result` in 32: from ALU `resultado`.
- `alu_zero` in 1: from ALU `zeroFlag`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_result` out 32: captured ALU result; 0 when illegal.
- `rsp_zero` out 1: captured zero flag; 1 when illegal.
- `rsp_taken` out 1: branch condition met (BEQ/BNE only).
- `rsp_illegal` out 1: opcode/funct not supported.
- `rsp_tag` out TAG_W: tag of the request.

## Operation
- FSM with three states:
  - IDLE: `req_ready`=1. On accept, register operands and decoded select, then go to EXEC.
  - EXEC: lasts one cycle; the ALU evaluates registered inputs. At the edge, capture `alu_result`/`alu_zero` into the response registers, compute taken/illegal, and go to RESP.
  - RESP: `rsp_valid`=1.
    - `rsp_ready`=1 and `req_valid`=1: response retires and a new request is accepted in the same edge, then go to EXEC.
    - `rsp_ready`=1 and `req_valid`=0: go to IDLE.
    - `rsp_ready`=0: hold all `rsp_*` stable.
- `req_ready` = (state==IDLE) or (state==RESP and `rsp_ready`); forced 0 while `rst_n` low.
- Decode, R-type (opcode 000000):
  - funct 100100 AND → 0000
  - funct 100101 OR → 0001
  - funct 100000 ADD → 0010
  - funct 100010 SUB → 0110
  - funct 101010 SLT → 0111
  - funct 100111 NOR → 1100
- Decode, I-type:
  - 001000 ADDI → 0010
  - 001100 ANDI → 0000
  - 001101 ORI → 0001
  - 001010 SLTI → 0111
  - 100011 LW and 101011 SW → 0010 (address)
  - 000100 BEQ → 0110
  - 000101 BNE → 0110 (see Configuration)
- Illegal requests:
  - Any other opcode/funct is illegal: `alu_sel` driven 0000 and the EXEC cycle is still spent.
  - Response carries `rsp_illegal`=1, `rsp_result`=0, `rsp_zero`=1, `rsp_taken`=0.
- Taken: BEQ → `alu_zero`; BNE → !`alu_zero`; all other ops → 0.
- Arithmetic is 32-bit wrap-around; no overflow detection. SLT/SLTI compare is unsigned (ALU behaviour), passed through unchanged.

## Timing
- Reset (async, `rst_n` low):
  - State goes to IDLE.
  - `alu_op1`, `alu_op2`, `alu_sel`, `rsp_result`, `rsp_tag` = 0.
  - `rsp_valid`, `rsp_zero`, `rsp_taken`, `rsp_illegal` = 0.
  - `req_ready` = 0.
- Reset asserted in EXEC or RESP drops the in-flight operation; no response is produced.
- Latency: request accepted at edge N → `rsp_valid` high after edge N+1.
- Sustained throughput: one op per 2 cycles with `rsp_ready` held 1.
- `alu_op1`/`alu_op2`/`alu_sel` are registered and change only on accept; they stay stable through EXEC and RESP.
- `rsp_*` change only on the EXEC→RESP edge; stable while `rsp_valid` and not `rsp_ready`.

## Configuration
- Macro: `ALU_ISSUE_BNE_EN`.
  - Defined: BNE (000101) decodes to 0110 with taken = !zero.
  - Undefined: BNE is illegal like any unsupported opcode.

## Structure
- Package `alu_issue_pkg` holds:
  - ALU select constants (AND, OR, ADD, SUB, SLT, NOR).
  - Opcode and funct constants.
  - FSM state typedef (IDLE/EXEC/RESP).
- One sub-module, `alu_issue_dec`: combinational opcode/funct → {sel, is_beq, is_bne, illegal}. The macro is applied there.

## Test plan
- ADD: a=5, b=7 → `alu_sel`=0010 during EXEC; rsp_result=12, zero=0, taken=0, tag echoed.
- SUB then BEQ back-to-back with `rsp_ready`=1:
  - SUB a=9, b=9 → result 0, zero=1.
  - BEQ a=3, b=3 → taken=1; BEQ is accepted in the same edge the SUB response retires.
- Backpressure: `rsp_ready`=0 for 5 cycles after an NOR a=0, b=0 → rsp_result=FFFF_FFFF held stable, `req_ready`=0 throughout.
- Illegal: funct 000000 under opcode 000000 → rsp_illegal=1, result=0, zero=1. BNE with macro undefined → illegal; with macro defined, a=1, b=2 → taken=1.
- SLT unsigned: a=FFFF_FFFF, b=1 → result 0.
- Reset: assert `rst_n` low during EXEC → no response; all outputs 0; after release, `req_ready`=1.
